// File: rtl/aw_write_arbiter.sv
// Two-master AXI write-path arbiter. It grants one master per burst using round-robin
// priority, holds the grant until WLAST, and routes B responses back in issue order.
module aw_write_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             M0_AWVALID,
  output logic             M0_AWREADY,
  input  logic             M1_AWVALID,
  output logic             M1_AWREADY,
  output logic             S_AWVALID,
  input  logic             S_AWREADY,
  output logic [1:0]       Selected_Slave,
  input  logic             M0_WVALID,
  input  logic             M0_WLAST,
  output logic             M0_WREADY,
  input  logic             M1_WVALID,
  input  logic             M1_WLAST,
  output logic             M1_WREADY,
  output logic             S_WVALID,
  output logic             S_WLAST,
  input  logic             S_WREADY,
  input  logic             S_BVALID,
  output logic             S_BREADY,
  output logic             M0_BVALID,
  output logic             M1_BVALID,
  input  logic             M0_BREADY,
  input  logic             M1_BREADY,
  output logic [CNT_W-1:0] outstanding
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e           state_q;
  logic             grant_q;
  logic             rr_ptr_q;
  logic [1:0]       sel_q;
  logic             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic in_addr, in_data, any_req, pick;
  logic aw_hs, w_last_hs, b_hs;
  logic fifo_empty, fifo_head;

  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);
  assign any_req = M0_AWVALID | M1_AWVALID;
  // The round-robin pointer only matters when both masters request in the same cycle.
  assign pick    = (M0_AWVALID & M1_AWVALID) ? rr_ptr_q : M1_AWVALID;

  assign S_AWVALID  = in_addr & (grant_q ? M1_AWVALID : M0_AWVALID);
  assign M0_AWREADY = in_addr & ~grant_q & S_AWREADY;
  assign M1_AWREADY = in_addr & grant_q & S_AWREADY;

  assign S_WVALID  = in_data & (grant_q ? M1_WVALID : M0_WVALID);
  assign S_WLAST   = in_data & (grant_q ? M1_WLAST : M0_WLAST);
  assign M0_WREADY = in_data & ~grant_q & S_WREADY;
  assign M1_WREADY = in_data & grant_q & S_WREADY;

  assign aw_hs     = S_AWVALID & S_AWREADY;
  assign w_last_hs = S_WVALID & S_WREADY & S_WLAST;

  // B routing is independent of the FSM; an empty FIFO masks any stray BVALID.
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_q[rd_ptr_q];
  assign M0_BVALID  = ~fifo_empty & ~fifo_head & S_BVALID;
  assign M1_BVALID  = ~fifo_empty & fifo_head & S_BVALID;
  assign S_BREADY   = ~fifo_empty & (fifo_head ? M1_BREADY : M0_BREADY);
  assign b_hs       = S_BVALID & S_BREADY;

  assign Selected_Slave = sel_q;
  assign outstanding    = count_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      sel_q    <= 2'b11;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req && (count_q < MaxCnt)) begin
            grant_q <= pick;
            sel_q   <= {1'b0, pick};
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (aw_hs) state_q <= StData;
        end
        StData: begin
          if (w_last_hs) begin
            rr_ptr_q <= ~grant_q;
            sel_q    <= 2'b11;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      fifo_q   <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (aw_hs) begin
        fifo_q[wr_ptr_q] <= grant_q;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (b_hs) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({aw_hs, b_hs})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_aw_write_arbiter.sv
// Self-checking bench for aw_write_arbiter. A queue of issued master ids is the
// scoreboard for B routing; the queue size is the expected occupancy.
module tb_aw_write_arbiter;

  localparam int unsigned MaxOut = 4;
  localparam int unsigned CntW   = $clog2(MaxOut + 1);

  logic            ACLK, ARESET;
  logic            M0_AWVALID, M0_AWREADY, M1_AWVALID, M1_AWREADY;
  logic            S_AWVALID, S_AWREADY;
  logic [1:0]      Selected_Slave;
  logic            M0_WVALID, M0_WLAST, M0_WREADY, M1_WVALID, M1_WLAST, M1_WREADY;
  logic            S_WVALID, S_WLAST, S_WREADY;
  logic            S_BVALID, S_BREADY, M0_BVALID, M1_BVALID, M0_BREADY, M1_BREADY;
  logic [CntW-1:0] outstanding;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb [$];

  aw_write_arbiter #(.MAX_OUTSTANDING(MaxOut)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .M0_AWVALID    (M0_AWVALID),
    .M0_AWREADY    (M0_AWREADY),
    .M1_AWVALID    (M1_AWVALID),
    .M1_AWREADY    (M1_AWREADY),
    .S_AWVALID     (S_AWVALID),
    .S_AWREADY     (S_AWREADY),
    .Selected_Slave(Selected_Slave),
    .M0_WVALID     (M0_WVALID),
    .M0_WLAST      (M0_WLAST),
    .M0_WREADY     (M0_WREADY),
    .M1_WVALID     (M1_WVALID),
    .M1_WLAST      (M1_WLAST),
    .M1_WREADY     (M1_WREADY),
    .S_WVALID      (S_WVALID),
    .S_WLAST       (S_WLAST),
    .S_WREADY      (S_WREADY),
    .S_BVALID      (S_BVALID),
    .S_BREADY      (S_BREADY),
    .M0_BVALID     (M0_BVALID),
    .M1_BVALID     (M1_BVALID),
    .M0_BREADY     (M0_BREADY),
    .M1_BREADY     (M1_BREADY),
    .outstanding   (outstanding)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    M0_AWVALID = 0; M1_AWVALID = 0; S_AWREADY = 0;
    M0_WVALID = 0; M0_WLAST = 0; M1_WVALID = 0; M1_WLAST = 0; S_WREADY = 0;
    S_BVALID = 0; M0_BREADY = 0; M1_BREADY = 0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_sel"}, Selected_Slave, 2'b11);
    check_eq({tag, "_outstanding"}, outstanding, 0);
    check_eq({tag, "_s_awvalid"}, S_AWVALID, 0);
    check_eq({tag, "_s_wvalid"}, S_WVALID, 0);
    check_eq({tag, "_s_bready"}, S_BREADY, 0);
    check_eq({tag, "_m_bvalid"}, {M0_BVALID, M1_BVALID}, 0);
  endtask

  // Called at a negedge; ends at the negedge after the reset is released.
  task automatic apply_reset();
    ARESET = 1'b1;
    clear_inputs();
    S_BVALID = 1'b1;
    M0_BREADY = 1'b1;
    @(negedge ACLK);
    check_quiet("rst_hold");
    ARESET = 1'b0;
    S_BVALID = 1'b0;
    M0_BREADY = 1'b0;
    sb.delete();
    @(negedge ACLK);
    check_quiet("rst_release");
  endtask

  // Presents a B response and checks it is routed to the scoreboard's head id.
  task automatic b_drive_check();
    logic exp_id;
    exp_id = sb.pop_front();
    S_BVALID = 1'b1; M0_BREADY = 1'b1; M1_BREADY = 1'b1;
    #1;
    check_eq("b_route_m0", M0_BVALID, !exp_id);
    check_eq("b_route_m1", M1_BVALID, exp_id);
    check_eq("s_bready", S_BREADY, 1);
  endtask

  task automatic do_b();
    b_drive_check();
    @(negedge ACLK);
    S_BVALID = 1'b0;
    check_eq("outstanding_after_b", outstanding, sb.size());
  endtask

  task automatic run_burst(input bit req0, input bit req1, input int beats, input bit id,
                           input int exp_wait, input bit with_b);
    int waited;
    M0_AWVALID = req0; M1_AWVALID = req1; S_AWREADY = 1'b1;
    waited = 0;
    do begin
      @(negedge ACLK);
      waited++;
    end while (Selected_Slave == 2'b11 && waited < 20);
    check_eq("grant_latency", waited, exp_wait);
    check_eq("grant_id", Selected_Slave, {1'b0, id});
    check_eq("s_awvalid", S_AWVALID, 1);
    check_eq("awready_granted", id ? M1_AWREADY : M0_AWREADY, 1);
    check_eq("awready_other", id ? M0_AWREADY : M1_AWREADY, 0);
    if (with_b) b_drive_check();
    sb.push_back(id);
    @(negedge ACLK);
    S_BVALID = 1'b0;
    if (!(req0 && req1)) begin
      M0_AWVALID = 1'b0; M1_AWVALID = 1'b0;
    end
    check_eq("outstanding_after_aw", outstanding, sb.size());
    check_eq("awready_in_data", {M0_AWREADY, M1_AWREADY, S_AWVALID}, 0);
    for (int b = 0; b < beats; b++) begin
      if (id) begin
        M1_WVALID = 1'b1; M1_WLAST = (b == beats - 1);
      end else begin
        M0_WVALID = 1'b1; M0_WLAST = (b == beats - 1);
      end
      S_WREADY = 1'b1;
      #1;
      check_eq("s_wvalid", S_WVALID, 1);
      check_eq("s_wlast", S_WLAST, (b == beats - 1));
      check_eq("wready_granted", id ? M1_WREADY : M0_WREADY, 1);
      check_eq("wready_other", id ? M0_WREADY : M1_WREADY, 0);
      @(negedge ACLK);
    end
    M0_WVALID = 0; M0_WLAST = 0; M1_WVALID = 0; M1_WLAST = 0; S_WREADY = 0;
    #1;
    check_eq("idle_sel", Selected_Slave, 2'b11);
    check_eq("idle_s_wvalid", S_WVALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    clear_inputs();
    @(negedge ACLK);
    apply_reset();

    // Single M1 burst of four beats.
    run_burst(0, 1, 4, 1, 1, 0);
    check_eq("single_outstanding", outstanding, 1);
    do_b();

    // Contention from reset: strict alternation starting with M0.
    apply_reset();
    run_burst(1, 1, 1, 0, 1, 0);
    run_burst(1, 1, 1, 1, 1, 0);
    run_burst(1, 1, 1, 0, 1, 0);
    run_burst(1, 1, 1, 1, 1, 0);

    // FIFO full: M0 keeps requesting but must not be granted.
    M1_AWVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check_eq("full_no_grant", Selected_Slave, 2'b11);
      check_eq("full_no_awvalid", S_AWVALID, 0);
    end
    check_eq("full_outstanding", outstanding, MaxOut);
    do_b();
    check_eq("full_no_early_grant", Selected_Slave, 2'b11);
    run_burst(1, 0, 1, 0, 1, 0);

    // Drain, stalling once while the head belongs to M0.
    do_b();
    S_BVALID = 1'b1; M0_BREADY = 1'b0; M1_BREADY = 1'b1;
    #1;
    check_eq("stall_s_bready", S_BREADY, 0);
    check_eq("stall_m0_bvalid", M0_BVALID, 1);
    check_eq("stall_m1_bvalid", M1_BVALID, 0);
    @(negedge ACLK);
    S_BVALID = 1'b0;
    check_eq("stall_outstanding", outstanding, sb.size());
    repeat (3) do_b();

    // Issue order M1, M0, M1; then a simultaneous push/pop across the pointer wrap.
    run_burst(0, 1, 2, 1, 1, 0);
    run_burst(1, 0, 3, 0, 1, 0);
    run_burst(0, 1, 1, 1, 1, 0);
    do_b();
    run_burst(1, 0, 2, 0, 1, 1);
    check_eq("pushpop_outstanding", outstanding, 2);
    do_b();
    do_b();

    // Reset in the middle of a data phase.
    M0_AWVALID = 1'b1; S_AWREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    M0_AWVALID = 1'b0;
    M0_WVALID = 1'b1; S_WREADY = 1'b1; S_BVALID = 1'b1; M0_BREADY = 1'b1;
    #1;
    check_eq("pre_rst_s_wvalid", S_WVALID, 1);
    check_eq("pre_rst_outstanding", outstanding, 1);
    check_eq("pre_rst_m0_bvalid", M0_BVALID, 1);
    ARESET = 1'b1;
    #1;
    check_quiet("mid_data_rst");
    check_eq("mid_data_rst_wready", {M0_WREADY, M1_WREADY}, 0);
    @(negedge ACLK);
    clear_inputs();
    ARESET = 1'b0;
    sb.delete();
    @(negedge ACLK);
    check_quiet("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
